bcd_score_counter: RTL
======================

BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, giving the number of BCD digits (legal range 1..8).
REQ-002 The block SHALL have parameter SATURATE, default 1: 1 = clamp at all-nines on overflow, 0 = wrap modulo 10^DIGITS.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 score  input  1  score request level; each rising edge is one scoring event.
REQ-006 pts  input  4  points per event, binary 0..15, sampled at the event.
REQ-007 dec  input  1  1 = event subtracts pts (penalty); 0 = event adds pts; sampled at the event.
REQ-008 clr  input  1  synchronous clear of the current score only.
REQ-009 digits  output  4*DIGITS  current score, BCD, digit 0 in bits [3:0].
REQ-010 hi_digits  output  4*DIGITS  high score, BCD, same layout.
REQ-011 new_hi  output  1  one-cycle pulse when hi_digits takes a new value.
REQ-012 ovf  output  1  one-cycle pulse when an add exceeds 10^DIGITS-1.
REQ-013 udf  output  1  one-cycle pulse when a subtract would go below 0.

Function
REQ-014 The block SHALL register score into score_q every cycle; an event SHALL be score=1 while score_q=0.
REQ-015 On an event, digits SHALL take the new value at the same rising edge that samples score high (latency 1 edge).
REQ-016 pts values 10..15 SHALL be treated as 9; pts=0 SHALL leave digits unchanged with no pulses.
REQ-017 Add SHALL be a per-digit BCD ripple add: pts added to digit 0; any digit sum >9 SHALL subtract 10 and carry 1 into the next digit.
REQ-018 Add overflow (carry out of the top digit), SATURATE=1: digits SHALL become all 9s and ovf SHALL pulse.
REQ-019 Add overflow, SATURATE=0: digits SHALL hold the sum modulo 10^DIGITS and ovf SHALL pulse.
REQ-020 Subtract SHALL be a per-digit BCD borrow subtract; if the result would be negative, digits SHALL become 0 and udf SHALL pulse (no wrap in either mode).
REQ-021 A result of exactly 10^DIGITS-1 or exactly 0 SHALL NOT pulse ovf/udf.
REQ-022 clr=1 SHALL set digits to 0 at the next edge, take priority over a simultaneous event (event discarded, no pulses), and leave hi_digits unchanged.
REQ-023 One edge after digits changes, if digits > hi_digits (unsigned BCD compare), hi_digits SHALL take digits and new_hi SHALL pulse for exactly one cycle.
REQ-024 Events on consecutive cycles are impossible (edge detect); an event in the cycle the high-score compare runs SHALL NOT be lost, and the compare SHALL use the newest digits on the following edge.
REQ-025 ovf, udf and new_hi SHALL each be high for exactly one cycle per cause and low otherwise.
REQ-026 All outputs SHALL be driven directly from registers.

Reset
REQ-027 rst=0 SHALL immediately set digits=0, hi_digits=0, new_hi=0, ovf=0, udf=0, and internal compare state to idle, independent of clk.
REQ-028 rst=0 SHALL set score_q=1, so a score input held high through reset release produces no event until it goes low then high.
REQ-029 Reset asserted mid-operation SHALL discard any pending compare; no pulse SHALL appear after reset release without a new event.

Verification (DIGITS=2)
REQ-030 Ten events pts=1, dec=0 from reset -> digits 0x01..0x09 then 0x10; new_hi pulses one cycle after each update; hi_digits=0x10.
REQ-031 digits=0x95, event pts=7: SATURATE=1 -> digits=0x99, ovf one cycle; SATURATE=0 -> digits=0x02, ovf one cycle.
REQ-032 digits=0x03, event pts=5, dec=1 -> digits=0x00, udf one cycle; hi_digits unchanged.
REQ-033 digits=0x42, hi=0x42, clr=1 on the same edge as an event pts=3 -> digits=0x00, hi_digits=0x42, no pulses.
REQ-034 score held high across rst release, then 4 cycles high -> no change; drop low, raise again -> exactly one event.
REQ-035 pts=12 event from digits=0x00 -> digits=0x09; pts=0 event -> no change, no pulses.

Source files
------------

// File: rtl/bcd_score_counter.sv
// BCD score counter with a high-score register. A rising edge on `score` adds or subtracts
// `pts`, and the high-score compare runs one edge after the score changes.
module bcd_score_counter #(
  parameter int DIGITS   = 2,
  parameter int SATURATE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                score,
  input  logic [3:0]          pts,
  input  logic                dec,
  input  logic                clr,
  output logic [4*DIGITS-1:0] digits,
  output logic [4*DIGITS-1:0] hi_digits,
  output logic                new_hi,
  output logic                ovf,
  output logic                udf
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic         score_q;
  logic         cmp_pend;
  logic [3:0]   p_eff;
  logic         take;
  logic [W:0]   add_r;
  logic [W:0]   sub_r;
  logic [W-1:0] nxt;
  logic         nxt_ovf;
  logic         nxt_udf;

  function automatic logic [3:0] clamp_pts(input logic [3:0] p);
    return (p > 4'd9) ? 4'd9 : p;
  endfunction

  // Ripple add; returns {carry_out, sum}
  function automatic logic [W:0] bcd_add(input logic [W-1:0] v, input logic [3:0] p);
    logic [4:0]   s;
    logic [3:0]   c;
    logic [W-1:0] r;
    c = p;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, v[4*i +: 4]} + {1'b0, c};
      if (s > 5'd9) begin
        r[4*i +: 4] = s[3:0] - 4'd10;
        c = 4'd1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 4'd0;
      end
    end
    return {c[0], r};
  endfunction

  // Ripple borrow subtract; returns {borrow_out, difference}
  function automatic logic [W:0] bcd_sub(input logic [W-1:0] v, input logic [3:0] p);
    logic [4:0]   s;
    logic [3:0]   c;
    logic [W-1:0] r;
    c = p;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, v[4*i +: 4]} - {1'b0, c};
      if (s[4]) begin
        r[4*i +: 4] = s[3:0] + 4'd10;
        c = 4'd1;
      end else begin
        r[4*i +: 4] = s[3:0];
        c = 4'd0;
      end
    end
    return {c[0], r};
  endfunction

  always_comb begin
    p_eff   = clamp_pts(pts);
    take    = score & ~score_q & (p_eff != 4'd0);
    add_r   = bcd_add(digits, p_eff);
    sub_r   = bcd_sub(digits, p_eff);
    nxt     = digits;
    nxt_ovf = 1'b0;
    nxt_udf = 1'b0;
    if (dec) begin
      if (sub_r[W]) begin
        nxt     = '0;
        nxt_udf = 1'b1;
      end else begin
        nxt = sub_r[W-1:0];
      end
    end else begin
      nxt = add_r[W-1:0];
      if (add_r[W]) begin
        nxt_ovf = 1'b1;
        if (SATURATE != 0) nxt = ALL_NINES;
      end
    end
  end

  // The compare reads the digits register as it stands at that edge; a later digits
  // change in the same edge re-arms the compare for the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q   <= 1'b1;
      cmp_pend  <= 1'b0;
      digits    <= '0;
      hi_digits <= '0;
      new_hi    <= 1'b0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      score_q <= score;
      new_hi  <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      if (cmp_pend) begin
        cmp_pend <= 1'b0;
        if (digits > hi_digits) begin
          hi_digits <= digits;
          new_hi    <= 1'b1;
        end
      end
      if (clr) begin
        digits <= '0;
        if (digits != '0) cmp_pend <= 1'b1;
      end else if (take) begin
        digits <= nxt;
        ovf    <= nxt_ovf;
        udf    <= nxt_udf;
        if (nxt != digits) cmp_pend <= 1'b1;
      end
    end
  end

endmodule
